// File: rtl/alu_muldiv_unit_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: funct codes,
// the R-type ALUOp class and the sequencing state encoding.
package alu_muldiv_unit_pkg;

  localparam logic [5:0] MFHI  = 6'b010000;
  localparam logic [5:0] MTHI  = 6'b010001;
  localparam logic [5:0] MFLO  = 6'b010010;
  localparam logic [5:0] MTLO  = 6'b010011;
  localparam logic [5:0] MULT  = 6'b011000;
  localparam logic [5:0] MULTU = 6'b011001;
  localparam logic [5:0] DIV   = 6'b011010;
  localparam logic [5:0] DIVU  = 6'b011011;

  localparam logic [2:0] ALUOP_RTYPE = 3'b010;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_t;

endpackage

// File: rtl/alu_muldiv_unit_md_iter_core.sv
// Iterative datapath: one shift-add multiply step or one restoring divide
// step per cycle on unsigned magnitudes.
// Ports:
//   clk, reset   clock and synchronous active-high reset
//   load         capture operand magnitudes and clear accumulator/counter
//   step         perform one iteration
//   is_div       select divide (1) or multiply (0) for load and step
//   a_mag, b_mag operand magnitudes (multiplicand/dividend, multiplier/divisor)
//   acc, sreg    MUL: product {acc,sreg};  DIV: remainder acc, quotient sreg
//   last         the current step is the final one (count == WIDTH-1)
module md_iter_core #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             step,
  input  logic             is_div,
  input  logic [WIDTH-1:0] a_mag,
  input  logic [WIDTH-1:0] b_mag,
  output logic [WIDTH-1:0] acc,
  output logic [WIDTH-1:0] sreg,
  output logic             last
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] addend;
  logic [CNT_W-1:0] count;
  logic [WIDTH:0]   mul_sum;
  logic             div_ge;
  logic [WIDTH-1:0] div_diff;

  // The partial remainder never exceeds WIDTH bits after a subtract, so the
  // difference can be formed modulo 2^WIDTH from the shifted remainder.
  always_comb begin
    mul_sum  = {1'b0, acc} + (sreg[0] ? {1'b0, addend} : '0);
    div_ge   = ({acc, sreg[WIDTH-1]} >= {1'b0, addend});
    div_diff = {acc[WIDTH-2:0], sreg[WIDTH-1]} - addend;
  end

  assign last = (count == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      acc    <= '0;
      sreg   <= '0;
      addend <= '0;
      count  <= '0;
    end else if (load) begin
      acc    <= '0;
      count  <= '0;
      sreg   <= is_div ? a_mag : b_mag;
      addend <= is_div ? b_mag : a_mag;
    end else if (step) begin
      count <= count + CNT_W'(1);
      if (is_div) begin
        if (div_ge) begin
          acc  <= div_diff;
          sreg <= {sreg[WIDTH-2:0], 1'b1};
        end else begin
          acc  <= {acc[WIDTH-2:0], sreg[WIDTH-1]};
          sreg <= {sreg[WIDTH-2:0], 1'b0};
        end
      end else begin
        acc  <= mul_sum[WIDTH:1];
        sreg <= {mul_sum[0], sreg[WIDTH-1:1]};
      end
    end
  end

endmodule

// File: rtl/alu_muldiv_unit.sv
// HI/LO multiply/divide unit beside the EX-stage ALU. Decodes MULT(U),
// DIV(U), MFHI/MFLO/MTHI/MTLO and owns the HI/LO registers.
// Ports:
//   clk, reset     clock and synchronous active-high reset
//   start, ALUOp,  issue strobe and decode fields (start honoured only for
//   Funct          R-type ALUOp and a recognised funct while idle)
//   op_a, op_b     rs / rt operands
//   ready, busy    unit availability / MULT-DIV in flight
//   done, div_zero completion pulse and divide-by-zero flag
//   result         MFHI/MFLO read mux
//   hi, lo         architectural HI/LO
//
// state | meaning
// IDLE  | waiting for issue; MTHI/MTLO write here
// CALC  | WIDTH iterations in the core
// FIX   | sign correction and HI/LO write-back
module alu_muldiv_unit
  import alu_muldiv_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       ALUOp,
  input  logic [5:0]       Funct,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  state_t           state;
  logic             op_div, sgn_res, sgn_rem, dz;
  logic             is_rtype, dec_md, dec_signed, accept;
  logic             a_neg, b_neg, last;
  logic [WIDTH-1:0] a_mag, b_mag, acc, sreg;
  logic [WIDTH-1:0] q_fix, r_fix;
  logic [2*WIDTH-1:0] prod_fix;
  logic             unused_aluop;

  assign unused_aluop = ALUOp[3];

  assign is_rtype   = (ALUOp[2:0] == ALUOP_RTYPE);
  assign dec_md     = (Funct[5:2] == 4'b0110);
  assign dec_signed = ~Funct[0];
  assign accept     = (state == IDLE) && start && is_rtype;

  assign a_neg = dec_signed & op_a[WIDTH-1];
  assign b_neg = dec_signed & op_b[WIDTH-1];
  assign a_mag = a_neg ? -op_a : op_a;
  assign b_mag = b_neg ? -op_b : op_b;

  md_iter_core #(.WIDTH(WIDTH)) u_core (
    .clk    (clk),
    .reset  (reset),
    .load   (accept && dec_md),
    .step   (state == CALC),
    .is_div (accept ? Funct[1] : op_div),
    .a_mag  (a_mag),
    .b_mag  (b_mag),
    .acc    (acc),
    .sreg   (sreg),
    .last   (last)
  );

  // Remainder follows the dividend sign; with a zero divisor the remainder
  // magnitude is the dividend magnitude, so this restores op_a exactly.
  always_comb begin
    prod_fix = sgn_res ? -{acc, sreg} : {acc, sreg};
    q_fix    = sgn_res ? -sreg : sreg;
    r_fix    = sgn_rem ? -acc : acc;
  end

  assign ready = ~busy;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      div_zero <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      op_div   <= 1'b0;
      sgn_res  <= 1'b0;
      sgn_rem  <= 1'b0;
      dz       <= 1'b0;
    end else begin
      done     <= 1'b0;
      div_zero <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            if (dec_md) begin
              state   <= CALC;
              busy    <= 1'b1;
              op_div  <= Funct[1];
              sgn_res <= a_neg ^ b_neg;
              sgn_rem <= a_neg;
              dz      <= (op_b == '0);
            end else if (Funct == MTHI) begin
              hi <= op_a;
            end else if (Funct == MTLO) begin
              lo <= op_a;
            end
          end
        end
        CALC: if (last) state <= FIX;
        FIX: begin
          state    <= IDLE;
          busy     <= 1'b0;
          done     <= 1'b1;
          div_zero <= op_div & dz;
          if (op_div) begin
            lo <= dz ? '1 : q_fix;
            hi <= r_fix;
          end else begin
            hi <= prod_fix[2*WIDTH-1:WIDTH];
            lo <= prod_fix[WIDTH-1:0];
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    result = '0;
    if (Funct == MFHI)      result = hi;
    else if (Funct == MFLO) result = lo;
  end

endmodule

// File: tb/tb_alu_muldiv_unit.sv
module tb_alu_muldiv_unit;
  import alu_muldiv_unit_pkg::*;

  logic        clk = 1'b0;
  logic        reset, start;
  logic [3:0]  ALUOp;
  logic [5:0]  Funct;
  logic [31:0] op_a, op_b;
  logic        ready, busy, done, div_zero;
  logic [31:0] result, hi, lo;

  int tests = 0;
  int failed = 0;
  int wd_cycles, wd_busy, wd_done_pulses;
  logic wd_seen, wd_dz;

  alu_muldiv_unit #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .ALUOp(ALUOp), .Funct(Funct),
    .op_a(op_a), .op_b(op_b), .ready(ready), .busy(busy), .done(done),
    .div_zero(div_zero), .result(result), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Call at a negedge; returns just after the accepting posedge.
  task automatic issue(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    ALUOp = 4'b0010; Funct = f; op_a = a; op_b = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Counts negedges after the accepting edge until done (bounded).
  task automatic wait_done();
    wd_cycles = 0; wd_busy = 0; wd_seen = 1'b0; wd_dz = 1'b0;
    for (int i = 0; i < 100 && !wd_seen; i++) begin
      @(negedge clk);
      wd_cycles++;
      if (busy) wd_busy++;
      if (done) begin wd_seen = 1'b1; wd_dz = div_zero; end
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; ALUOp = 4'b0000; Funct = 6'b0; op_a = '0; op_b = '0;
    repeat (3) @(posedge clk);
    @(negedge clk); reset = 1'b0;
    check("rst_hi", hi, 0);
    check("rst_lo", lo, 0);
    check("rst_busy", busy, 0);
    check("rst_ready", ready, 1);
    check("rst_done", done, 0);
    check("rst_dz", div_zero, 0);

    // MULTU max * max
    @(negedge clk);
    issue(MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
    wait_done();
    check("multu_seen", wd_seen, 1);
    check("multu_latency", wd_cycles, 34);
    check("multu_busy_cycles", wd_busy, 33);
    check("multu_busy_at_done", busy, 0);
    check("multu_hi", hi, 32'hFFFFFFFE);
    check("multu_lo", lo, 32'h00000001);
    check("multu_dz", wd_dz, 0);

    // MULT -3 * 7, then MFHI/MFLO read
    issue(MULT, 32'hFFFFFFFD, 32'd7);
    wait_done();
    check("mult_latency", wd_cycles, 34);
    check("mult_hi", hi, 32'hFFFFFFFF);
    check("mult_lo", lo, 32'hFFFFFFEB);
    Funct = MFHI; #1;
    check("mfhi_result", result, 32'hFFFFFFFF);
    Funct = MFLO; #1;
    check("mflo_result", result, 32'hFFFFFFEB);
    Funct = MULT; #1;
    check("other_result", result, 0);

    // DIV -7 / 2 and DIVU of the same bits
    @(negedge clk);
    issue(DIV, 32'hFFFFFFF9, 32'd2);
    wait_done();
    check("div_lo", lo, 32'hFFFFFFFD);
    check("div_hi", hi, 32'hFFFFFFFF);
    check("div_dz", wd_dz, 0);
    issue(DIVU, 32'hFFFFFFF9, 32'd2);
    wait_done();
    check("divu_lo", lo, 32'h7FFFFFFC);
    check("divu_hi", hi, 32'h00000001);

    // Divide by zero
    issue(DIVU, 32'h00001234, 32'd0);
    wait_done();
    check("dz_latency", wd_cycles, 34);
    check("dz_flag", wd_dz, 1);
    check("dz_hi", hi, 32'h00001234);
    check("dz_lo", lo, 32'hFFFFFFFF);
    @(negedge clk);
    check("dz_flag_drops", div_zero, 0);

    // Signed overflow MIN / -1
    issue(DIV, 32'h80000000, 32'hFFFFFFFF);
    wait_done();
    check("ovf_lo", lo, 32'h80000000);
    check("ovf_hi", hi, 32'h00000000);
    check("ovf_dz", wd_dz, 0);

    // Start with non-R-type ALUOp is ignored
    @(negedge clk);
    ALUOp = 4'b0000; Funct = MULT; op_a = 32'd3; op_b = 32'd3; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    @(negedge clk);
    check("aluop_ignored_busy", busy, 0);
    check("aluop_ignored_lo", lo, 32'h80000000);

    // MTHI while idle
    issue(MTHI, 32'hA5A5A5A5, 32'd0);
    @(negedge clk);
    check("mthi_hi", hi, 32'hA5A5A5A5);
    check("mthi_busy", busy, 0);
    check("mthi_lo_kept", lo, 32'h80000000);

    // MTLO while busy is dropped
    issue(MULTU, 32'd2, 32'd3);
    @(negedge clk);
    check("busy_ready", ready, 0);
    issue(MTLO, 32'hA5A5A5A5, 32'd0);
    @(negedge clk);
    check("mtlo_busy_lo", lo, 32'h80000000);
    wait_done();
    check("small_mul_lo", lo, 32'd6);
    check("small_mul_hi", hi, 32'd0);

    // New MULT issued in the done cycle
    issue(MULT, 32'd5, 32'hFFFFFFFE);
    wait_done();
    check("b2b_latency", wd_cycles, 34);
    check("b2b_lo", lo, 32'hFFFFFFF6);
    check("b2b_hi", hi, 32'hFFFFFFFF);

    // Reset in the middle of a MULT
    issue(MULT, 32'd9, 32'd9);
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("abort_busy", busy, 0);
    check("abort_hi", hi, 0);
    check("abort_lo", lo, 0);
    reset = 1'b0;
    wd_done_pulses = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (done) wd_done_pulses++;
    end
    check("abort_no_done", wd_done_pulses, 0);
    check("abort_lo_after", lo, 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/alu_muldiv_unit.md
Name: alu_muldiv_unit

Overview:
- Parametrised successor to the CPU's ALU control decode. It adds the HI/LO multiply/divide path that the multi-cycle CPU lacks.
- Decodes ALUOp/Funct for the R-type MULT, MULTU, DIV, DIVU, MFHI, MFLO, MTHI and MTLO instructions.
- Runs a 1-bit-per-cycle iterative shift-add multiplier or restoring divider, and owns the HI/LO architectural registers.
- Sits beside the main ALU in the EX stage. The controller stalls on busy and reads HI/LO through result.

Parameters:
- WIDTH, 32: operand, HI and LO width. Legal range is 4 and above.
- CNT_W, $clog2(WIDTH+1): localparam, iteration counter width. Not overridable.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  issue strobe. Valid only when ALUOp[2:0]==3'b010.
- ALUOp  in  4  main-control ALU opcode.
- Funct  in  6  instruction funct field.
- op_a  in  WIDTH  rs value: multiplicand, dividend, or MTHI/MTLO data.
- op_b  in  WIDTH  rt value: multiplier or divisor.
- ready  out  1  equals ~busy. start is accepted only when ready is high.
- busy  out  1  high while a MULT/DIV is in flight.
- done  out  1  one-cycle pulse when HI/LO hold the new MULT/DIV result.
- div_zero  out  1  pulses together with done when the divisor was 0.
- result  out  WIDTH  combinational: HI when Funct==MFHI, LO when Funct==MFLO, otherwise 0.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.

Behaviour:
- Decode rules:
  - Funct codes: MFHI=010000, MTHI=010001, MFLO=010010, MTLO=010011, MULT=011000, MULTU=011001, DIV=011010, DIVU=011011.
  - Operation is signed = ~Funct[0].
  - Any other Funct, or ALUOp[2:0]!=3'b010, ignores start.
- Reset values: hi=0, lo=0, busy=0, done=0, div_zero=0, state=IDLE.
- Reset mid-operation aborts immediately. HI/LO are cleared and no done pulse is issued.
- State machine: IDLE -> CALC -> FIX -> IDLE.
- IDLE:
  - start with MULT/DIV: latch |op_a| and |op_b| (two's-complement magnitude if signed and negative), the result sign flags, op type, and count=0. Go to CALC.
  - start with MTHI or MTLO: write op_a to hi or lo at that edge. No busy, no done.
- CALC:
  - Runs exactly WIDTH cycles, count 0..WIDTH-1. Each cycle processes one operand bit.
  - MUL: shift-add producing a 2*WIDTH unsigned product.
  - DIV: restoring divide producing a WIDTH-bit quotient and remainder.
- FIX (1 cycle):
  - MUL: negate the product if the operand signs differ. Write hi/lo from it.
  - DIV: negate the quotient if the signs differ. The remainder takes the sign of the dividend. Write lo=quotient, hi=remainder.
  - Then go to IDLE.
- Timing: for a start accepted at edge k, busy=1 in cycles k+1..k+WIDTH+1. done=1 and busy=0 in cycle k+WIDTH+2, and hi/lo are already updated in that cycle. Latency is WIDTH+2, i.e. 34 for WIDTH=32.
- Divide by zero: runs the same latency. Result is hi=op_a (original), lo=all ones, with div_zero=1 alongside done.
- Signed overflow, MIN / -1: lo=MIN, hi=0. No flag.
- While busy, all starts are ignored, including MTHI/MTLO. There is no queuing.
- Back-to-back: a start in the same cycle as done is accepted.
- result is purely combinational on Funct and the current hi/lo. During busy it returns the old values; the controller stalls, so these are never consumed.
- Operand inputs need be stable only at the accepting edge.

Decomposition:
- Shared package holds:
  - Funct localparams: MFHI, MTHI, MFLO, MTLO, MULT, MULTU, DIV, DIVU.
  - ALUOp R-type code 3'b010.
  - State encoding: IDLE, CALC, FIX.
- One natural sub-module, md_iter_core:
  - Holds the accumulator/remainder, the shift register and the counter. Performs one MUL or DIV step per cycle.
  - The top level keeps decode, sign handling, the FSM and HI/LO.

Test Plan (WIDTH=32):
- MULTU: op_a=0xFFFFFFFF, op_b=0xFFFFFFFF -> done at start+34, hi=0xFFFFFFFE, lo=0x00000001, busy high for 33 cycles.
- MULT: op_a=-3 (0xFFFFFFFD), op_b=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB. Then MFHI/MFLO Funct gives result=hi/lo.
- DIV: op_a=-7, op_b=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). DIVU with the same bits -> lo=0x7FFFFFFC, hi=0x00000001.
- DIVU: op_a=0x1234, op_b=0 -> done at +34, div_zero=1, hi=0x1234, lo=0xFFFFFFFF. DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- MTHI 0xA5A5A5A5 while idle -> hi updated next edge with no busy. Same MTLO while busy -> lo unchanged. A new MULT in the done cycle -> accepted.
- Reset asserted at start+10 of a MULT -> next cycle busy=0, hi=lo=0, and no done pulse follows.
